// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch sequencer feeding the decoder ROM
//
// Walks the program counter through program memory, reads one 8-bit
// instruction word per instruction (two for ldi, which carries an immediate
// byte in the following word) and presents the result to the execute stage
// over a valid/ready handshake.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   en          run enable, looked at in IDLE and at instruction boundaries
//   mem_rd      program-memory read strobe
//   mem_addr    program-memory read address (zero while mem_rd is low)
//   mem_data    program-memory read data, valid one cycle after mem_rd
//   opcode      instruction bits [7:4]
//   operand     instruction bits [3:0]
//   imm         immediate byte, only written by ldi
//   inst_valid  opcode/operand/imm hold an instruction for the execute stage
//   inst_ready  execute stage accepts the instruction this cycle
//   jump        redirect request
//   jump_addr   redirect target
//   pc          address of the next instruction word to fetch

module inst_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic [7:0]        imm,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_IMM_FETCH,
        S_IMM_WAIT,
        S_ISSUE
    } state_t;

    localparam logic [3:0] OP_LDI = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [3:0]        operand_q, operand_d;
    logic [7:0]        imm_q, imm_d;
    logic              valid_q, valid_d;

    // Natural ADDR_W-bit overflow gives the required wrap to address 0,
    // so an ldi at the top address takes its immediate from address 0.
    logic [ADDR_W-1:0] pc_inc;
    assign pc_inc = pc_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            imm_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            imm_q     <= imm_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        imm_d     = imm_q;

        case (state_q)
            S_IDLE: begin
                if (jump) begin
                    pc_d = jump_addr;
                end
                if (en) begin
                    state_d = S_FETCH;
                end
            end

            // A jump here still lets the read strobe go out, but staying in
            // FETCH means its returning data is never looked at.
            S_FETCH: begin
                if (jump) begin
                    pc_d = jump_addr;
                end else begin
                    pc_d    = pc_inc;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (jump) begin
                    pc_d    = jump_addr;
                    state_d = S_FETCH;
                end else begin
                    opcode_d  = mem_data[7:4];
                    operand_d = mem_data[3:0];
                    state_d   = (mem_data[7:4] == OP_LDI) ? S_IMM_FETCH : S_ISSUE;
                end
            end

            S_IMM_FETCH: begin
                if (jump) begin
                    pc_d    = jump_addr;
                    state_d = S_FETCH;
                end else begin
                    pc_d    = pc_inc;
                    state_d = S_IMM_WAIT;
                end
            end

            // imm is only written when the ldi is going to be issued, so an
            // aborted ldi leaves the previous immediate visible.
            S_IMM_WAIT: begin
                if (jump) begin
                    pc_d    = jump_addr;
                    state_d = S_FETCH;
                end else begin
                    imm_d   = mem_data;
                    state_d = S_ISSUE;
                end
            end

            // A jump while stalled only retargets pc; the held instruction
            // stays on the outputs until it is accepted.
            S_ISSUE: begin
                if (jump) begin
                    pc_d = jump_addr;
                end
                if (inst_ready) begin
                    state_d = en ? S_FETCH : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered valid: high exactly while the state register is ISSUE.
        valid_d = (state_d == S_ISSUE);
    end

    assign mem_rd     = (state_q == S_FETCH) || (state_q == S_IMM_FETCH);
    assign mem_addr   = mem_rd ? pc_q : '0;
    assign opcode     = opcode_q;
    assign operand    = operand_q;
    assign imm        = imm_q;
    assign inst_valid = valid_q;
    assign pc         = pc_q;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch sequencer that produces the opcode stream consumed by the instruction decoder ROM. It maintains the program counter and reads 8-bit instruction words from program memory over a fixed-latency read port. For `ldi` (opcode `0xF`) it also fetches the following immediate byte. Each decoded-ready instruction is presented to the execute stage over a valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, default 8: program-memory address width; the PC wraps modulo 2^ADDR_W.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset; synchronous and active-high.
- `en` input 1: run enable; sampled only in IDLE and at instruction boundaries.
- `mem_rd` output 1: read strobe to program memory.
- `mem_addr` output ADDR_W: read address; meaningful only while `mem_rd`=1.
- `mem_data` input 8: read data; valid exactly one cycle after `mem_rd`=1.
- `opcode` output 4: instruction bits [7:4], drives the decoder ROM.
- `operand` output 4: instruction bits [3:0].
- `imm` output 8: immediate byte; updated only by `ldi`.
- `inst_valid` output 1: an instruction is on `opcode`/`operand`/`imm`.
- `inst_ready` input 1: the execute stage accepts the instruction this cycle.
- `jump` input 1: redirect request.
- `jump_addr` input ADDR_W: redirect target.
- `pc` output ADDR_W: address of the next instruction word to fetch.

## Operation
- States: IDLE, FETCH, WAIT, IMM_FETCH, IMM_WAIT, ISSUE.
- IDLE: if `en`=1, go to FETCH; otherwise stay in IDLE.
- FETCH: drive `mem_rd`=1 and `mem_addr`=`pc`; set `pc`<=`pc`+1; go to WAIT.
- WAIT: latch `opcode`<=`mem_data[7:4]` and `operand`<=`mem_data[3:0]`.
  - If `mem_data[7:4]`=`0xF`, go to IMM_FETCH.
  - Otherwise go to ISSUE.
- IMM_FETCH: drive `mem_rd`=1 and `mem_addr`=`pc`; set `pc`<=`pc`+1; go to IMM_WAIT.
- IMM_WAIT: latch `imm`<=`mem_data`; go to ISSUE.
- ISSUE: hold `inst_valid`=1. On `inst_ready`=1:
  - Go to FETCH if `en`=1, else to IDLE.
- Output stability: `opcode`, `operand` and `imm` must not change while `inst_valid`=1 and `inst_ready`=0.
- PC arithmetic: ADDR_W-bit unsigned increment, wraps from 2^ADDR_W-1 to 0.
  - An `ldi` at the last address takes its immediate from address 0.
- Jump:
  - `jump`=1 in any state except IDLE or ISSUE: set `pc`<=`jump_addr`; any in-flight fetch (WAIT, IMM_FETCH, IMM_WAIT) is discarded; go to FETCH.
  - `jump`=1 in ISSUE with `inst_ready`=1: the handshake completes (the instruction counts as consumed), then `pc`<=`jump_addr` and go to FETCH (or IDLE if `en`=0).
  - `jump`=1 in ISSUE with `inst_ready`=0: set `pc`<=`jump_addr`; stay in ISSUE; the held instruction is still delivered.
  - `jump`=1 in IDLE: set `pc`<=`jump_addr`; state follows `en`.
  - A discarded fetch never asserts `inst_valid` and never updates `imm`.
- `jump` takes priority over the FETCH-state PC increment.
- `en` deasserted mid-instruction: the current instruction completes and is issued; the block stops at the next boundary.

## Timing
- Reset values, all outputs and state:
  - state = IDLE, `pc`=0, `mem_rd`=0, `mem_addr`=0.
  - `opcode`=0, `operand`=0, `imm`=0, `inst_valid`=0.
- Reset asserted mid-instruction aborts it in the same edge; no `inst_valid` pulse follows.
- Non-`ldi` instruction: `mem_rd` in cycle N, data sampled at N+1, `inst_valid`=1 from N+2.
  - Minimum throughput: 3 cycles per instruction with `inst_ready` tied high.
- `ldi` instruction: `inst_valid`=1 from N+4; minimum 5 cycles per instruction.
- From `en` rising in IDLE: first `mem_rd` one cycle later.
- `inst_valid` is registered; `mem_rd` and `mem_addr` are decoded from state and `pc`.
- There is no combinational path from `inst_ready` or `jump` to any output.

## Test plan
- Reset, then `en`=1 with memory {0x13, 0x42} and `inst_ready`=1:
  - Issues opcode 1/operand 3, then opcode 4/operand 2.
  - `inst_valid` rises at cycles 3 and 6 after `en`; `pc` reads 2 afterwards.
- `ldi` with memory {0xF5, 0xA7, 0x00}:
  - Issues opcode F, operand 5, `imm`=0xA7 with two `mem_rd` pulses (addresses 0, 1).
  - The next fetch is from address 2.
- Backpressure: hold `inst_ready`=0 for 4 cycles in ISSUE.
  - `inst_valid`, `opcode` and `imm` stay stable; no `mem_rd` is issued; exactly one instruction is accepted.
- Jump during IMM_WAIT to 0x20:
  - No instruction is issued for the `ldi`; `imm` is unchanged; the next `mem_addr`=0x20.
- Wrap-around: `ADDR_W`=8, jump to 0xFF where 0xFF holds `0xF0` and 0x00 holds 0x99:
  - Issues `imm`=0x99; `pc`=0x01 afterwards.
- Reset asserted while in WAIT:
  - Next cycle shows all reset values; no `inst_valid`; fetching restarts at address 0 when `en`=1.
